fifo_set_seq: RTL and testbench
===============================

Name: fifo_set_seq

Overview:
- Sequencer for a bank of DIM fifo_set delay buffers that feed the systolic array.
- Loads one row of operands per fifo through a valid/ready stream (overwrite via WrEn), then drives the common shift enable for exactly FIFO_DEPTH cycles to drain the bank into the array.
- Honours array backpressure and reports busy/done to the top-level command logic.

Parameters:
- DIM, 8, number of fifo_set instances (rows); also the number of row writes per job.
- FIFO_DEPTH, 16, depth of each fifo; equals the number of shift cycles per job.
- BITS, 64, width of one fifo entry.
- IN_DEPTH, 8, entries written per fifo per WrEn (fifo INPUT_DEPTH); IN_DEPTH <= FIFO_DEPTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a job; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE
- row_valid  in  1  row_data holds the next fifo row
- row_ready  out  1  sequencer accepts a row this cycle
- row_data  in  BITS x IN_DEPTH (unpacked)  row payload
- wr_en  out  DIM  one-hot WrEn to the fifo bank
- wr_row  out  BITS x IN_DEPTH  in_array to all fifos (pass-through of row_data)
- shift_en  out  1  common en to all fifos
- shift_d  out  BITS  d input to all fifos; constant 0
- array_ready  in  1  array can accept a column this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of job
- shift_cnt  out  clog2(FIFO_DEPTH+1)  shifts completed in current job

Behaviour:
- Reset (async, rst_n=0): state IDLE, load_cnt=0, shift_cnt=0, done=0. Combinational outputs row_ready, wr_en, shift_en and busy are all 0 because they decode from IDLE. Reset mid-job discards the job; fifo contents are cleared by their own reset.
- States: IDLE, LOAD, STREAM, DONE.
- IDLE: start=1 -> LOAD, load_cnt=0, shift_cnt=0. row_valid is ignored (row_ready=0).
- LOAD:
  - row_ready=1.
  - accept = row_valid & row_ready.
  - wr_en = accept ? (1 << load_cnt) : 0, combinational, so the fifo captures on the same edge as the accept.
  - wr_row = row_data at all times.
  - Each accept increments load_cnt.
  - Accept with load_cnt==DIM-1 -> STREAM.
  - Rows land in fifo 0 first, ascending.
- STREAM:
  - shift_en = array_ready, combinational; shift_d=0.
  - Each cycle with shift_en=1 increments shift_cnt.
  - shift with shift_cnt==FIFO_DEPTH-1 -> DONE, and shift_cnt becomes FIFO_DEPTH.
  - array_ready=0 stalls the job: no shift and counters held, indefinitely.
- DONE: done=1 for exactly this one cycle, then -> IDLE. shift_cnt holds FIFO_DEPTH until the next start.
- wr_en and shift_en are never high in the same cycle, since they come from mutually exclusive states. This is required because the fifo gives WrEn priority.
- abort=1 in any non-IDLE state -> IDLE next edge:
  - no done pulse;
  - outputs are suppressed in the abort cycle (wr_en=0, shift_en=0, row_ready=0);
  - abort has priority over start, accept and shift.
- start while busy is ignored. start and abort both high in IDLE stay in IDLE.
- Counters: load_cnt width clog2(DIM); shift_cnt saturates at FIFO_DEPTH and never wraps.
- Latency: minimum job length is DIM + FIFO_DEPTH + 1 cycles from the start edge to the done pulse, with row_valid=1 and array_ready=1 throughout.

Decomposition:
- Package fifo_seq_pkg:
  - state enum seq_state_e {IDLE, LOAD, STREAM, DONE};
  - width helper localparams for load_cnt and shift_cnt;
  - row_t typedef (BITS-wide word).
- Single module; no sub-module is warranted. The fifo_set bank is instantiated by the parent, not inside this block.

Test Plan (DIM=4, FIFO_DEPTH=8, BITS=8, IN_DEPTH=8):
- Basic job: start, 4 back-to-back rows 0x10..0x13, array_ready=1.
  - wr_en = 0001, 0010, 0100, 1000 on consecutive cycles.
  - shift_en high for 8 cycles, then done pulses once; total 13 cycles.
  - shift_cnt=8 after done; fifo 0 outputs its loaded entries in order.
- Row gaps: row_valid toggles 1,0,1,0...
  - wr_en is asserted only on accept cycles; STREAM is entered only after the 4th accept.
  - No shift_en occurs during LOAD.
- Backpressure: array_ready=0 for cycles 3-5 of STREAM.
  - shift_en=0 and shift_cnt frozen at 2 during the stall.
  - done arrives 3 cycles later than the basic job.
- Abort: abort asserted after 2 rows.
  - Next cycle busy=0, no done, wr_en=0.
  - A subsequent start restarts at wr_en=0001.
- Ignored inputs:
  - start pulsed during STREAM causes no change.
  - row_valid in IDLE gives row_ready=0 and wr_en=0.
  - start with abort both high in IDLE keeps busy=0.
- Reset mid-STREAM: rst_n low at shift_cnt=5.
  - All outputs go 0 immediately (asynchronously).
  - After release the block is IDLE and shift_cnt=0.

Source files
------------

// File: rtl/fifo_seq_pkg.sv
// Shared types and width helpers for the fifo_set bank sequencer.
package fifo_seq_pkg;

    // Job phases: load one row per fifo, stream the bank out, pulse done.
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DONE
    } seq_state_e;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Default geometry of the bank.
    localparam int DEF_DIM        = 8;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_BITS       = 64;

    localparam int LOAD_CNT_W  = cnt_width(DEF_DIM);
    localparam int SHIFT_CNT_W = cnt_width(DEF_FIFO_DEPTH + 1);

    // One fifo entry at the default width.
    typedef logic [DEF_BITS-1:0] row_t;

endpackage

// File: rtl/fifo_set_seq.sv
// Sequencer for a bank of DIM fifo_set delay buffers: loads one row per fifo
// through a valid/ready stream, then drives the common shift enable for
// FIFO_DEPTH accepted cycles to drain the bank into the systolic array.
module fifo_set_seq
    import fifo_seq_pkg::*;
#(
    parameter int DIM        = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int BITS       = 64,
    parameter int IN_DEPTH   = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic                                  row_valid,
    output logic                                  row_ready,
    input  logic [BITS-1:0]                       row_data [IN_DEPTH],
    output logic [DIM-1:0]                        wr_en,
    output logic [BITS-1:0]                       wr_row   [IN_DEPTH],
    output logic                                  shift_en,
    output logic [BITS-1:0]                       shift_d,
    input  logic                                  array_ready,
    output logic                                  busy,
    output logic                                  done,
    output logic [cnt_width(FIFO_DEPTH + 1)-1:0]  shift_cnt
);

    localparam int LW = cnt_width(DIM);
    localparam int SW = cnt_width(FIFO_DEPTH + 1);

    seq_state_e    state;
    logic [LW-1:0] load_cnt;
    logic          accept;

    // Output decode from the current state; abort masks every strobe.
    always_comb begin
        row_ready = (state == LOAD) && !abort;
        accept    = row_ready && row_valid;
        wr_en     = accept ? (DIM'(1) << load_cnt) : '0;
        shift_en  = (state == STREAM) && array_ready && !abort;
        busy      = (state != IDLE);
    end

    assign wr_row  = row_data;
    assign shift_d = '0;

    // Job FSM with load/shift counters and a registered done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            load_cnt  <= '0;
            shift_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state     <= LOAD;
                        load_cnt  <= '0;
                        shift_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (accept) begin
                        load_cnt <= load_cnt + LW'(1);
                        if (load_cnt == LW'(DIM - 1)) begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (shift_en) begin
                        if (shift_cnt != SW'(FIFO_DEPTH)) begin
                            shift_cnt <= shift_cnt + SW'(1);
                        end
                        if (shift_cnt == SW'(FIFO_DEPTH - 1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_set_seq.sv
// Self-checking bench for fifo_set_seq: a directed vector table, hand-written
// corner sequences and a randomized run against a job-level reference model.
module tb_fifo_set_seq;

    localparam int DIM        = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int BITS       = 8;
    localparam int IN_DEPTH   = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start, abort, row_valid, array_ready;
    logic            row_ready, shift_en, busy, done;
    logic [BITS-1:0] row_data [IN_DEPTH];
    logic [BITS-1:0] wr_row   [IN_DEPTH];
    logic [DIM-1:0]  wr_en;
    logic [BITS-1:0] shift_d;
    logic [3:0]      shift_cnt;

    fifo_set_seq #(
        .DIM       (DIM),
        .FIFO_DEPTH(FIFO_DEPTH),
        .BITS      (BITS),
        .IN_DEPTH  (IN_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_data   (row_data),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .shift_en   (shift_en),
        .shift_d    (shift_d),
        .array_ready(array_ready),
        .busy       (busy),
        .done       (done),
        .shift_cnt  (shift_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h want %0h", name, idx, got, exp);
        end
    endtask

    // Job-level reference: rows loaded, shifts done, and whether a job is open.
    bit m_job;
    int m_rows, m_shifts;
    bit e_rr, e_sh, e_busy, e_done;
    int e_wr, e_cnt;

    task automatic model_eval();
        bit finishing, loading, streaming;
        finishing = m_job && (m_shifts == FIFO_DEPTH);
        loading   = m_job && (m_rows < DIM);
        streaming = m_job && (m_rows == DIM) && (m_shifts < FIFO_DEPTH);
        e_busy = m_job;
        e_done = finishing;
        e_cnt  = m_shifts;
        e_rr   = loading && !abort;
        e_wr   = (e_rr && row_valid) ? (1 << m_rows) : 0;
        e_sh   = streaming && array_ready && !abort;
    endtask

    task automatic model_update();
        if (!m_job) begin
            if (start && !abort) begin
                m_job = 1; m_rows = 0; m_shifts = 0;
            end
        end else if (abort) begin
            m_job = 0;
        end else if (m_shifts == FIFO_DEPTH) begin
            m_job = 0;
        end else if (e_wr != 0) begin
            m_rows++;
        end else if (e_sh) begin
            m_shifts++;
        end
    endtask

    task automatic model_reset();
        m_job = 0; m_rows = 0; m_shifts = 0;
    endtask

    task automatic drive(input bit s, input bit a, input bit rv, input bit ar);
        @(negedge clk);
        start = s; abort = a; row_valid = rv; array_ready = ar;
        for (int i = 0; i < IN_DEPTH; i++) row_data[i] = BITS'($urandom);
        #1;
    endtask

    task automatic check_model(input int idx);
        int bad;
        model_eval();
        chk("row_ready", idx, 32'(row_ready), 32'(e_rr));
        chk("wr_en", idx, 32'(wr_en), 32'(e_wr));
        chk("shift_en", idx, 32'(shift_en), 32'(e_sh));
        chk("busy", idx, 32'(busy), 32'(e_busy));
        chk("done", idx, 32'(done), 32'(e_done));
        chk("shift_cnt", idx, 32'(shift_cnt), 32'(e_cnt));
        bad = 0;
        for (int i = 0; i < IN_DEPTH; i++) if (wr_row[i] !== row_data[i]) bad++;
        chk("wr_row", idx, 32'(bad), 0);
        chk("shift_d", idx, 32'(shift_d), 0);
        model_update();
    endtask

    task automatic step(input bit s, input bit a, input bit rv, input bit ar, input int idx);
        drive(s, a, rv, ar);
        check_model(idx);
    endtask

    typedef struct {
        bit       s, a, rv, ar;
        bit       rr, sh, bsy, dn;
        int       wr, cnt;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int n, done_at;
        bit seen;

        // Directed table: start+abort in IDLE, then a basic job with a
        // stray start during STREAM, ending back in IDLE.
        vecs[0] = '{1,1,1,1, 0,0,0,0, 0,0};
        vecs[1] = '{1,0,1,1, 0,0,0,0, 0,0};
        for (int k = 0; k < DIM; k++) vecs[2 + k] = '{0,0,1,1, 1,0,1,0, 1 << k, 0};
        for (int k = 0; k < FIFO_DEPTH; k++) vecs[6 + k] = '{(k == 2),0,1,1, 0,1,1,0, 0, k};
        vecs[14] = '{0,0,1,1, 0,0,1,1, 0,8};
        vecs[15] = '{0,0,1,1, 0,0,0,0, 0,8};

        start = 0; abort = 0; row_valid = 0; array_ready = 0;
        for (int i = 0; i < IN_DEPTH; i++) row_data[i] = '0;
        rst_n = 0;
        model_reset();
        #12;
        chk("rst_busy", 0, 32'(busy), 0);
        chk("rst_done", 0, 32'(done), 0);
        chk("rst_cnt", 0, 32'(shift_cnt), 0);
        chk("rst_ready", 0, 32'(row_ready), 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].s, vecs[i].a, vecs[i].rv, vecs[i].ar);
            chk("tv_row_ready", i, 32'(row_ready), 32'(vecs[i].rr));
            chk("tv_wr_en", i, 32'(wr_en), 32'(vecs[i].wr));
            chk("tv_shift_en", i, 32'(shift_en), 32'(vecs[i].sh));
            chk("tv_busy", i, 32'(busy), 32'(vecs[i].bsy));
            chk("tv_done", i, 32'(done), 32'(vecs[i].dn));
            chk("tv_shift_cnt", i, 32'(shift_cnt), 32'(vecs[i].cnt));
            model_eval();
            model_update();
        end

        // Row gaps: row_valid toggles; STREAM only after the fourth accept.
        step(1, 0, 0, 1, 100);
        for (int k = 0; k < 2 * DIM; k++) step(0, 0, (k % 2) == 0, 1, 101);
        chk("gap_stream_entered", 0, 32'(shift_en), 1);
        for (int k = 0; k < FIFO_DEPTH + 2; k++) step(0, 0, 1, 1, 102);

        // Abort after two rows, then restart at fifo 0.
        step(1, 0, 1, 1, 200);
        step(0, 0, 1, 1, 201);
        step(0, 0, 1, 1, 202);
        step(0, 1, 1, 1, 203);
        chk("abort_wr_en", 0, 32'(wr_en), 0);
        step(0, 0, 1, 1, 204);
        chk("abort_busy", 0, 32'(busy), 0);
        chk("abort_done", 0, 32'(done), 0);
        step(1, 0, 0, 1, 205);
        step(0, 0, 1, 1, 206);
        chk("restart_wr_en", 0, 32'(wr_en), 1);
        step(0, 1, 0, 1, 207);
        step(0, 0, 0, 1, 208);

        // Backpressure: array_ready low on STREAM cycles 3-5 delays done by 3.
        step(1, 0, 1, 1, 300);
        seen = 0; done_at = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            step(0, 0, 1, !(c >= 7 && c <= 9), 301);
            if (c >= 7 && c <= 9) begin
                chk("stall_cnt", c, 32'(shift_cnt), 2);
                chk("stall_shift_en", c, 32'(shift_en), 0);
            end
            if (done) begin seen = 1; done_at = c; end
        end
        chk("bp_done_cycle", 0, 32'(done_at), DIM + FIFO_DEPTH + 1 + 3);
        step(0, 0, 0, 1, 302);

        // Asynchronous reset mid-STREAM at shift_cnt=5.
        step(1, 0, 1, 1, 400);
        n = 0;
        while (shift_cnt != 4'd5 && n < 40) begin
            step(0, 0, 1, 1, 401);
            n++;
        end
        chk("reach_cnt5", 0, 32'(shift_cnt), 5);
        #1;
        rst_n = 0;
        #1;
        chk("arst_busy", 0, 32'(busy), 0);
        chk("arst_shift_en", 0, 32'(shift_en), 0);
        chk("arst_cnt", 0, 32'(shift_cnt), 0);
        chk("arst_ready", 0, 32'(row_ready), 0);
        chk("arst_wr_en", 0, 32'(wr_en), 0);
        chk("arst_done", 0, 32'(done), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        step(0, 0, 1, 1, 402);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 600; k++) begin
            step(($urandom % 4) == 0, ($urandom % 24) == 0, ($urandom % 2) == 0,
                 ($urandom % 4) != 0, 1000 + k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
